// File: rtl/jtframe_bank_responder.sv
// Memory responder: fixed-latency burst reads and byte-masked writes, blocked by refresh.
// Reads return BURST words (address wraps within storage); writes commit on the last wait cycle.
`timescale 1ns/1ps
module jtframe_bank_responder #(
  parameter int AW       = 22,
  parameter int BURST    = 4,
  parameter int LAT      = 3,
  parameter int MEMAW    = 10,
  parameter int RFSH_CYC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [15:0]   din,
  input  logic [1:0]    dsn,
  input  logic          rfsh,
  output logic          ack,
  output logic          dok,
  output logic          rdy,
  output logic [15:0]   dout
);
  localparam int DEPTH = 1 << MEMAW;
  localparam int CW    = ($clog2(RFSH_CYC + 1) > 4) ? $clog2(RFSH_CYC + 1) : 4;
  localparam int IW    = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RFSH, ST_WAIT, ST_BURST} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [MEMAW-1:0] addr_q, addr_d, rd_ptr;
  logic [15:0]      din_q, din_d, dout_q, dout_d;
  logic [15:0]      mem_old, mem_wdat;
  logic [1:0]       dsn_q, dsn_d;
  logic             wr_q, wr_d, pend_q, pend_d;
  logic             ack_q, ack_d, dok_q, dok_d, rdy_q, rdy_d;
  logic             mem_we;
  logic [15:0]      mem_q [DEPTH];

  generate
    if (AW > MEMAW) begin : g_hi_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[AW-1:MEMAW];
    end
  endgenerate

  assign rd_ptr   = addr_q + MEMAW'(idx_q);
  assign mem_old  = mem_q[addr_q];
  // A set dsn bit protects the stored byte.
  assign mem_wdat = {dsn_q[1] ? mem_old[15:8] : din_q[15:8],
                     dsn_q[0] ? mem_old[7:0]  : din_q[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dsn_d   = dsn_q;
    wr_d    = wr_q;
    pend_d  = pend_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;
    dok_d   = 1'b0;
    rdy_d   = 1'b0;
    mem_we  = 1'b0;
    if (rfsh && state_q != ST_IDLE) pend_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (rfsh || pend_q) begin
          state_d = ST_RFSH;
          cnt_d   = CW'(RFSH_CYC - 1);
          pend_d  = 1'b0;
        end else if (rd || wr) begin
          addr_d  = addr[MEMAW-1:0];
          din_d   = din;
          dsn_d   = dsn;
          wr_d    = wr;
          ack_d   = 1'b1;
          cnt_d   = CW'(LAT - 1);
          idx_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_RFSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (wr_q) begin
          mem_we  = 1'b1;
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          dok_d  = 1'b1;
          dout_d = mem_q[rd_ptr];
          if (BURST == 1) begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = IW'(1);
            state_d = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        // The last word is presented while already back in IDLE, so the next request overlaps it.
        dok_d  = 1'b1;
        dout_d = mem_q[rd_ptr];
        if (idx_q == IW'(BURST - 1)) begin
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dsn_q   <= '0;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      dok_q   <= 1'b0;
      rdy_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dsn_q   <= dsn_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      dok_q   <= dok_d;
      rdy_q   <= rdy_d;
      dout_q  <= dout_d;
    end
  end

  // Storage survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= mem_wdat;
  end

  assign ack  = ack_q;
  assign dok  = dok_q;
  assign rdy  = rdy_q;
  assign dout = dout_q;
endmodule
